// File: rtl/hazard_if.sv
// Pipeline hazard bus between the 5-stage core datapath and hazard_ctrl.
// master = pipeline side, slave = hazard controller.
interface hazard_if;
   logic [4:0] id_rs1_i;
   logic [4:0] id_rs2_i;
   logic       id_use_rs1_i;
   logic       id_use_rs2_i;
   logic [4:0] ex_rd_i;
   logic       ex_write_en_i;
   logic       ex_load_i;
   logic [4:0] mem_rd_i;
   logic       mem_write_en_i;
   logic       mem_access_i;
   logic       dmem_ready_i;
   logic       redirect_i;
   logic       stall_pc_o;
   logic       stall_if_id_o;
   logic       flush_if_id_o;
   logic       stall_id_ex_o;
   logic       clear_id_ex_o;
   logic       stall_ex_mem_o;
   logic       fwrd_opA_type1_o;
   logic       fwrd_opB_type1_o;
   logic       fwrd_opA_type2_o;
   logic       fwrd_opB_type2_o;
   logic       err_o;

   modport master (
      output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             ex_rd_i, ex_write_en_i, ex_load_i,
             mem_rd_i, mem_write_en_i, mem_access_i, dmem_ready_i, redirect_i,
      input  stall_pc_o, stall_if_id_o, flush_if_id_o, stall_id_ex_o,
             clear_id_ex_o, stall_ex_mem_o,
             fwrd_opA_type1_o, fwrd_opB_type1_o, fwrd_opA_type2_o, fwrd_opB_type2_o,
             err_o
   );

   modport slave (
      input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             ex_rd_i, ex_write_en_i, ex_load_i,
             mem_rd_i, mem_write_en_i, mem_access_i, dmem_ready_i, redirect_i,
      output stall_pc_o, stall_if_id_o, flush_if_id_o, stall_id_ex_o,
             clear_id_ex_o, stall_ex_mem_o,
             fwrd_opA_type1_o, fwrd_opB_type1_o, fwrd_opA_type2_o, fwrd_opB_type2_o,
             err_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubble, dmem wait stall, redirect squash.
// Optional HAZARD_PERF_CNT_EN adds per-state cycle counters.
//
// state    | meaning
// RUN      | normal issue, forwarding active
// LD_STALL | cycle after a load-use bubble; load result now forwards from MEM
// MEM_WAIT | data memory access outstanding, whole pipe held
// FLUSH    | squashing wrong-path fetches after a redirect
module hazard_ctrl #(
   parameter int FLUSH_DEPTH  = 2,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] ld_stall_cnt_o,
   output logic [31:0] mem_wait_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, FLUSH} state_t;

   localparam int             WCW        = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
   localparam logic [WCW-1:0] WAIT_MAX   = WCW'(WAIT_TIMEOUT);
   localparam logic [1:0]     FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

   state_t         state, state_nx;
   logic [1:0]     flush_cnt, flush_cnt_nx;
   logic [WCW-1:0] wait_cnt, wait_cnt_nx;
   logic           redir_pend, redir_pend_nx;
   logic           err_q;

   logic dep_ex_a, dep_ex_b, dep_mem_a, dep_mem_b;
   logic mem_stall, flushing, redir, ld_use, timeout_hit;
   logic stall_pc, stall_if_id, flush_if_id, stall_id_ex, clear_id_ex, stall_ex_mem;
   logic fa1, fb1, fa2, fb2;

   always_comb begin
      dep_ex_a  = hz.id_use_rs1_i && (hz.id_rs1_i != 5'd0) && hz.ex_write_en_i  && (hz.id_rs1_i == hz.ex_rd_i);
      dep_ex_b  = hz.id_use_rs2_i && (hz.id_rs2_i != 5'd0) && hz.ex_write_en_i  && (hz.id_rs2_i == hz.ex_rd_i);
      dep_mem_a = hz.id_use_rs1_i && (hz.id_rs1_i != 5'd0) && hz.mem_write_en_i && (hz.id_rs1_i == hz.mem_rd_i);
      dep_mem_b = hz.id_use_rs2_i && (hz.id_rs2_i != 5'd0) && hz.mem_write_en_i && (hz.id_rs2_i == hz.mem_rd_i);

      mem_stall = (hz.mem_access_i || (state == MEM_WAIT)) && !hz.dmem_ready_i;
      // a flush interrupted by a dmem wait resumes with its remaining count
      flushing  = (state == FLUSH) || ((state == MEM_WAIT) && (flush_cnt != 2'd0));
      redir     = hz.redirect_i || redir_pend;
      ld_use    = hz.ex_load_i && (dep_ex_a || dep_ex_b);

      state_nx      = RUN;
      flush_cnt_nx  = flush_cnt;
      redir_pend_nx = redir_pend || (mem_stall && hz.redirect_i);
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      flush_if_id   = 1'b0;
      stall_id_ex   = 1'b0;
      clear_id_ex   = 1'b0;
      stall_ex_mem  = 1'b0;
      fa1           = 1'b0;
      fb1           = 1'b0;
      fa2           = 1'b0;
      fb2           = 1'b0;

      if (mem_stall) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         stall_id_ex  = 1'b1;
         stall_ex_mem = 1'b1;
         state_nx     = MEM_WAIT;
      end else if (flushing) begin
         flush_if_id  = 1'b1;
         clear_id_ex  = 1'b1;
         flush_cnt_nx = flush_cnt - 2'd1;
         state_nx     = (flush_cnt == 2'd1) ? RUN : FLUSH;
      end else if (redir) begin
         flush_if_id   = 1'b1;
         clear_id_ex   = 1'b1;
         redir_pend_nx = 1'b0;
         flush_cnt_nx  = FLUSH_LOAD;
         state_nx      = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
      end else if (ld_use) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
         clear_id_ex = 1'b1;
         state_nx    = LD_STALL;
      end else begin
         fa1 = dep_ex_a && !hz.ex_load_i;
         fb1 = dep_ex_b && !hz.ex_load_i;
         fa2 = !fa1 && dep_mem_a;
         fb2 = !fb1 && dep_mem_b;
      end

      wait_cnt_nx = '0;
      if (mem_stall)
         wait_cnt_nx = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      timeout_hit = (WAIT_TIMEOUT != 0) && mem_stall && (wait_cnt == WAIT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         flush_cnt  <= 2'd0;
         wait_cnt   <= '0;
         redir_pend <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         flush_cnt  <= flush_cnt_nx;
         wait_cnt   <= wait_cnt_nx;
         redir_pend <= redir_pend_nx;
         err_q      <= err_q || timeout_hit;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_stall_cnt_o <= 32'd0;
         mem_wait_cnt_o <= 32'd0;
         flush_cnt_o    <= 32'd0;
      end else begin
         if (state == LD_STALL) ld_stall_cnt_o <= ld_stall_cnt_o + 32'd1;
         if (state == MEM_WAIT) mem_wait_cnt_o <= mem_wait_cnt_o + 32'd1;
         if (state == FLUSH)    flush_cnt_o    <= flush_cnt_o + 32'd1;
      end
   end
`endif

   assign hz.stall_pc_o       = !rst && stall_pc;
   assign hz.stall_if_id_o    = !rst && stall_if_id;
   assign hz.flush_if_id_o    = !rst && flush_if_id;
   assign hz.stall_id_ex_o    = !rst && stall_id_ex;
   assign hz.clear_id_ex_o    = !rst && clear_id_ex;
   assign hz.stall_ex_mem_o   = !rst && stall_ex_mem;
   assign hz.fwrd_opA_type1_o = !rst && fa1;
   assign hz.fwrd_opB_type1_o = !rst && fb1;
   assign hz.fwrd_opA_type2_o = !rst && fa2;
   assign hz.fwrd_opB_type2_o = !rst && fb2;
   assign hz.err_o            = !rst && (err_q || timeout_hit);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table plus hand-written multi-cycle sequences,
// expected output words queued on drive and compared at the falling edge.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] exrd;
      logic       exwe;
      logic       exld;
      logic [4:0] memrd;
      logic       memwe;
      logic       acc;
      logic       rdy;
      logic       redir;
   } in_t;

   typedef struct {
      string       name;
      in_t         in;
      logic [10:0] exp;
   } vec_t;

   // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, clear_id_ex, stall_ex_mem, fA1, fB1, fA2, fB2, err}
   localparam logic [10:0] E_NONE  = 11'b000_0000_0000;
   localparam logic [10:0] E_LDU   = 11'b110_0100_0000;
   localparam logic [10:0] E_MEMW  = 11'b110_1010_0000;
   localparam logic [10:0] E_FLUSH = 11'b001_0100_0000;
   localparam logic [10:0] E_FA1   = 11'b000_0001_0000;
   localparam logic [10:0] E_FB1   = 11'b000_0000_1000;
   localparam logic [10:0] E_FA2   = 11'b000_0000_0100;
   localparam logic [10:0] E_FB2   = 11'b000_0000_0010;
   localparam logic [10:0] E_ERR   = 11'b000_0000_0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [10:0] exp_q[$];
   string       name_q[$];
   vec_t        tbl[12];

   hazard_if hz();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ld_stall_cnt, mem_wait_cnt, flush_cnt;
   logic [31:0] mw_base;
`endif

   hazard_ctrl #(.FLUSH_DEPTH(2), .WAIT_TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .ld_stall_cnt_o (ld_stall_cnt),
      .mem_wait_cnt_o (mem_wait_cnt),
      .flush_cnt_o    (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic in_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic [4:0] exrd, input logic exwe, input logic exld,
                              input logic [4:0] memrd, input logic memwe,
                              input logic acc, input logic rdy, input logic redir);
      in_t v;
      v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.exrd = exrd; v.exwe = exwe; v.exld = exld;
      v.memrd = memrd; v.memwe = memwe;
      v.acc = acc; v.rdy = rdy; v.redir = redir;
      return v;
   endfunction

   function automatic logic [10:0] outs();
      return {hz.stall_pc_o, hz.stall_if_id_o, hz.flush_if_id_o, hz.stall_id_ex_o,
              hz.clear_id_ex_o, hz.stall_ex_mem_o, hz.fwrd_opA_type1_o, hz.fwrd_opB_type1_o,
              hz.fwrd_opA_type2_o, hz.fwrd_opB_type2_o, hz.err_o};
   endfunction

   task automatic drive(input in_t v);
      hz.id_rs1_i       = v.rs1;
      hz.id_use_rs1_i   = v.u1;
      hz.id_rs2_i       = v.rs2;
      hz.id_use_rs2_i   = v.u2;
      hz.ex_rd_i        = v.exrd;
      hz.ex_write_en_i  = v.exwe;
      hz.ex_load_i      = v.exld;
      hz.mem_rd_i       = v.memrd;
      hz.mem_write_en_i = v.memwe;
      hz.mem_access_i   = v.acc;
      hz.dmem_ready_i   = v.rdy;
      hz.redirect_i     = v.redir;
   endtask

   task automatic check_now(input logic [10:0] e, input string nm);
      logic [10:0] exp_w;
      logic [10:0] act;
      string       n;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      exp_w = exp_q.pop_front();
      n     = name_q.pop_front();
      act   = outs();
      checks++;
      if (act !== exp_w) begin
         errors++;
         $display("FAIL %s: outputs got %b expected %b", n, act, exp_w);
      end
   endtask

   task automatic step(input in_t v, input logic [10:0] e, input string nm);
      drive(v);
      check_now(e, nm);
      @(posedge clk);
      #1;
   endtask

   in_t idle, mw, mr, ld5;

   initial begin
      idle = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      mw   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      mr   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      ld5  = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      tbl[0]  = '{"idle",          idle, E_NONE};
      tbl[1]  = '{"fwd_b_type1",   mk(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), E_FB1};
      tbl[2]  = '{"rd_zero",       mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_NONE};
      tbl[3]  = '{"fwd_a1_b2",     mk(5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), E_FA1 | E_FB2};
      tbl[4]  = '{"no_use_rs1",    mk(5'd3, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), E_NONE};
      tbl[5]  = '{"ex_no_we",      mk(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), E_FA2};
      tbl[6]  = '{"mem_both",      mk(5'd9, 1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), E_FA2 | E_FB2};
      tbl[7]  = '{"ld_use_rs2",    mk(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_LDU};
      tbl[8]  = '{"ld_then_fwd2",  mk(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), E_FB2};
      tbl[9]  = '{"ld_unused",     mk(5'd6, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
      tbl[10] = '{"ld_no_we",      mk(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
      tbl[11] = '{"mem_ready_now", mr, E_NONE};

      drive(mw);
      check_now(E_NONE, "reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         step(tbl[i].in, tbl[i].exp, tbl[i].name);

      step(ld5, E_LDU, "t1_ld_stall");
      step(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), E_FA2, "t1_fwd_type2");
      step(mk(5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E_LDU, "b2b_ld_1");
      step(mk(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0), E_LDU, "b2b_ld_2");
      step(idle, E_NONE, "b2b_done");

`ifdef HAZARD_PERF_CNT_EN
      mw_base = mem_wait_cnt;
`endif
      for (int i = 1; i <= 4; i++)
         step(mw, E_MEMW, $sformatf("t3_wait%0d", i));
      step(mr, E_NONE, "t3_ready");
      step(idle, E_NONE, "t3_run");
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (mem_wait_cnt - mw_base !== 32'd4) begin
         errors++;
         $display("FAIL perf_mem_wait: got %0d expected 4", mem_wait_cnt - mw_base);
      end
`endif

      step(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), E_MEMW, "rw_wait1");
      step(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), E_MEMW, "rw_wait2");
      step(mr, E_FLUSH, "rw_service");
      step(idle, E_FLUSH, "rw_flush2");
      step(idle, E_NONE, "rw_done");

      step(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), E_FLUSH, "t5_redirect");
      step(ld5, E_FLUSH, "t5_flush_ignores_ld");
      step(ld5, E_LDU, "t5_after_flush");
      step(idle, E_NONE, "t5_done");

      for (int i = 1; i <= 10; i++)
         step(mw, (i >= 8) ? (E_MEMW | E_ERR) : E_MEMW, $sformatf("t4_wait%0d", i));
      step(mr, E_ERR, "t4_ready");
      step(idle, E_ERR, "t4_sticky");

      step(mw, E_MEMW | E_ERR, "t6_wait1");
      rst = 1'b1;
      drive(mw);
      check_now(E_NONE, "t6_rst_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(idle, E_NONE, "t6_run_after_rst");
      step(tbl[1].in, E_FB1, "t6_fwd_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
